fft_out_unloader: RTL
=====================

# fft_out_unloader

Output-side stream unloader for the 32-point radix-2 FFT. Captures one full frame of 32 parallel complex results from the butterfly network in a single handshake and emits them one sample per beat on a valid/ready stream. Reorders the core's bit-reversed output into natural frequency order. Sits between the final butterfly stage and the downstream consumer, such as a magnitude block or host interface.

## Interface
Parameters:
- N, 32, points per frame; power of two.
- LOG2N, 5, index width; equals log2(N).
- W, 32, width of each real and imaginary word; treated as opaque data.
- BITREV, 1, 1 = output sample k is bank[bitrev(k)]; 0 = bank[k].

Ports:
- clk  in  1  rising-edge clock; the only clock.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  frame on in_r/in_i is valid.
- in_ready  out  1  unloader accepts a frame this cycle.
- in_r  in  N*W  packed real parts; sample j at [j*W +: W].
- in_i  in  N*W  packed imaginary parts; same packing as in_r.
- out_valid  out  1  out_r, out_i, out_idx and out_last are valid.
- out_ready  in  1  consumer accepts the current beat.
- out_r  out  W  real part of the current sample.
- out_i  out  W  imaginary part of the current sample.
- out_idx  out  LOG2N  natural-order frequency index k of the current beat.
- out_last  out  1  high on the beat with k = N-1.
- busy  out  1  high while a frame is held (state STREAM).

## Operation
- Storage:
  - One frame bank of N × 2W bits.
  - Beat counter cnt, LOG2N bits.
  - State register: IDLE or STREAM.
- Handshakes:
  - Input beat: in_valid & in_ready at a rising edge.
  - Output beat: out_valid & out_ready at a rising edge.
- IDLE:
  - in_ready = 1, out_valid = 0.
  - On an input beat: load all N samples into the bank, set cnt = 0, go to STREAM.
- STREAM:
  - out_valid = 1.
  - out_idx = cnt.
  - out_r/out_i = bank[BITREV ? bitrev(cnt) : cnt].
  - out_last = (cnt == N-1).
  - On an output beat with cnt < N-1: cnt increments by 1.
  - On an output beat with cnt == N-1 and no input beat: go to IDLE, cnt = 0.
- Back-to-back frames:
  - in_ready = IDLE | (STREAM & out_ready & out_last).
  - This is the only combinational path, out_ready → in_ready; it is documented and permitted.
  - If the last output beat and an input beat coincide: load the new frame, set cnt = 0, stay in STREAM. There is no bubble.
- Frame handling:
  - A frame is never overwritten or dropped while any of its beats are unsent.
  - The upstream core must hold in_r/in_i stable while in_valid & !in_ready (AXI-style).
- Output drive: out_r, out_i, out_idx and out_last are driven only from registers (bank, cnt, state). They have no combinational dependence on in_* or out_ready.
- bitrev(k) reverses the LOG2N index bits. For N=32: bitrev(1)=16, bitrev(3)=24, bitrev(6)=12.

## Timing
- Reset (rst low, asynchronous, immediate):
  - State = IDLE, cnt = 0, bank = 0.
  - Outputs: out_valid = 0, out_last = 0, busy = 0, out_idx = 0, out_r = out_i = 0, in_ready = 1.
- Reset release is synchronised to clk by the system. The first input beat is accepted on the first rising edge after rst goes high.
- Latency: the input beat at edge E gives out_valid = 1 with out_idx = 0 in the cycle after E.
- Throughput: with out_ready held high, a frame takes exactly N cycles. Continuous frames run at N cycles per frame.
- Stall: while out_valid & !out_ready, out_r, out_i, out_idx and out_last hold their values.
- Reset mid-frame: the partial frame is discarded. After release the block is in IDLE with no stale out_valid.
- in_valid asserted during STREAM other than on the last accepted beat: ignored, because in_ready = 0.

## Test plan
- Single frame: input sample j = (re j, im 100+j), BITREV=1, out_ready high → 32 beats, out_idx 0..31. Beat k carries re = bitrev(k), im = 100+bitrev(k); beat 1 → 16/116, beat 31 → 31/131. out_last only at k=31. First beat one cycle after acceptance.
- Back-to-back: second frame (re 200+j) held valid from the last beat of frame 1 → in_ready high in that cycle only; beat 0 of frame 2 (re 200) in the next cycle; no idle cycle.
- Random backpressure: out_ready toggled pseudo-randomly over 3 frames → outputs stable during every stall; all 96 samples delivered in order, none lost or duplicated; in_ready never high mid-frame.
- Early frame rejected: in_valid asserted with frame 2 at cnt = 10 → in_ready stays 0; frame 1 completes intact; frame 2 accepted on frame 1's last beat.
- Reset mid-frame: rst low at cnt = 7 → out_valid, busy and out_idx drop to 0 immediately, in_ready = 1. The next frame streams from out_idx 0 with correct data.
- BITREV=0 build: same stimulus as test 1 → beat k carries re = k; natural order preserved.

Source files
------------

// File: rtl/fft_out_unloader.sv
// fft_out_unloader: output-side unloader for the 32-point radix-2 FFT.
// Captures a full frame of N complex samples in one handshake and streams
// them out one per beat, reordering bit-reversed core output into natural
// frequency order when BITREV is set.
//
// Ports:
//   clk, rst               clock, async active-low reset
//   in_valid/in_ready      frame handshake; in_r/in_i packed N*W, sample j at [j*W +: W]
//   out_valid/out_ready    beat handshake
//   out_r/out_i            current sample, out_idx = natural-order index k
//   out_last               beat k = N-1
//   busy                   a frame is held

// One complex sample register of the frame bank.
module fft_out_lane #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] d_r,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_r,
  output logic [W-1:0] q_i
);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_r <= '0;
      q_i <= '0;
    end else if (load) begin
      q_r <= d_r;
      q_i <= d_i;
    end
  end
endmodule

module fft_out_unloader #(
  parameter int N      = 32,
  parameter int LOG2N  = 5,
  parameter int W      = 32,
  parameter int BITREV = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N*W-1:0]   in_r,
  input  logic [N*W-1:0]   in_i,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_r,
  output logic [W-1:0]     out_i,
  output logic [LOG2N-1:0] out_idx,
  output logic             out_last,
  output logic             busy
);
  typedef enum logic {IDLE, STREAM} state_t;

  localparam logic [LOG2N-1:0] LAST_IDX = LOG2N'(N-1);

  state_t                      state, state_nxt;
  logic [LOG2N-1:0]            cnt, cnt_nxt, cnt_rev, sel;
  logic [N-1:0][W-1:0]         bank_r, bank_i;
  logic                        stream, last, in_fire, out_fire;

  // Bank: one lane per frame sample, all loaded by the same input beat.
  genvar g;
  generate
    for (g = 0; g < N; g++) begin : g_lane
      fft_out_lane #(.W(W)) u_lane (
        .clk  (clk),
        .rst  (rst),
        .load (in_fire),
        .d_r  (in_r[g*W +: W]),
        .d_i  (in_i[g*W +: W]),
        .q_r  (bank_r[g]),
        .q_i  (bank_i[g])
      );
    end
    for (g = 0; g < LOG2N; g++) begin : g_rev
      assign cnt_rev[g] = cnt[LOG2N-1-g];
    end
  endgenerate

  assign stream   = (state == STREAM);
  assign last     = (cnt == LAST_IDX);
  assign sel      = (BITREV != 0) ? cnt_rev : cnt;

  // Output data path depends only on registers (bank, cnt, state).
  assign out_valid = stream;
  assign busy      = stream;
  assign out_idx   = cnt;
  assign out_last  = stream & last;
  assign out_r     = bank_r[sel];
  assign out_i     = bank_i[sel];

  // Only combinational path: out_ready -> in_ready, so the next frame can
  // load on the final beat with no bubble.
  assign in_ready = !stream | (out_ready & last);
  assign in_fire  = in_valid & in_ready;
  assign out_fire = stream & out_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (in_fire) begin
          state_nxt = STREAM;
          cnt_nxt   = '0;
        end
      end
      STREAM: begin
        if (out_fire) begin
          if (!last) begin
            cnt_nxt = cnt + LOG2N'(1);
          end else begin
            cnt_nxt   = '0;
            state_nxt = in_fire ? STREAM : IDLE;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end
endmodule
